wb_port_arbiter: RTL

//  Sequences the single register-file write port between two requesters:
//  - in-order pipeline commits (ALU result or PC+4);
//  - variable-latency data-memory load responses.

---
 rtl/wb_pkg.sv | 19 +
 rtl/wb_load_fifo.sv | 51 +++++
 rtl/wb_port_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Purpose : shared writeback-select encodings and register-file geometry.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package wb_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    // Writeback mux select encodings, shared with the writeback mux and decoder.
    localparam logic [1:0] WB_MEM = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    // Only ALU and PC+4 are legal selects coming from the pipeline side.
    function automatic logic wb_sel_legal(input logic [1:0] sel);
        return (sel == WB_ALU) || (sel == WB_PC4);
    endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// Purpose : small power-of-two FIFO holding load responses; wrap-around pointers
//           carrying one extra bit to tell full from empty.
// Latency : head_dat shows the oldest entry combinationally; push visible next cycle.
// Backpressure: push ignored while full, pop ignored while empty (callers gate both).
// Ports   : clk/rst, push/push_dat (write side), pop/head_dat (read side), full, empty.
module wb_load_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage needs no reset: entries are only observed once written.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    assign head_dat = mem[rd_ptr[AW-1:0]];
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/wb_port_arbiter.sv
// Purpose : arbitrates the single regfile write port between pipeline commits and
//           buffered load responses; tracks registers with loads outstanding.
// Latency : grant is combinational; wb_* / rf_* outputs register one cycle after grant.
// Backpressure: ld_ready = !fifo_full (not pop-aware); pipe_ready low stalls the pipeline.
// Ports   : ld_issue/ld_issue_rd (scoreboard set), ld_valid/ld_rd/ld_data/ld_ready
//           (response buffer), pipe_* (commit request), rd_busy (to hazard unit),
//           wb_sel/wb_mem/wb_alu/wb_pc4 (writeback mux), rf_we/rf_rd (regfile port).
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN       = wb_pkg::XLEN,
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_STALL  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_issue,
    input  logic [REG_AW-1:0] ld_issue_rd,
    input  logic              ld_valid,
    input  logic [REG_AW-1:0] ld_rd,
    input  logic [XLEN-1:0]   ld_data,
    output logic              ld_ready,
    input  logic              pipe_valid,
    input  logic [REG_AW-1:0] pipe_rd,
    input  logic [1:0]        pipe_wb_sel,
    input  logic [XLEN-1:0]   pipe_alu,
    input  logic [XLEN-1:0]   pipe_pc4,
    output logic              pipe_ready,
    output logic [31:0]       rd_busy,
    output logic [1:0]        wb_sel,
    output logic [XLEN-1:0]   wb_mem,
    output logic [XLEN-1:0]   wb_alu,
    output logic [XLEN-1:0]   wb_pc4,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_rd
);

    localparam int            SW        = $clog2(MAX_STALL + 1);
    localparam logic [SW-1:0] STALL_MAX = SW'(MAX_STALL);

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } ld_resp_t;

    ld_resp_t      push_ent;
    ld_resp_t      head_ent;
    logic          fifo_full;
    logic          fifo_empty;
    logic          l_elig;
    logic          p_elig;
    logic          grant_l;
    logic          grant_p;
    logic [SW-1:0] starve_cnt;
    logic [31:0]   busy_q;
    logic [31:0]   busy_set;
    logic [31:0]   busy_clr;

    // ---------------- load response buffer ----------------
    assign push_ent = '{rd: ld_rd, data: ld_data};
    assign ld_ready = !fifo_full;

    wb_load_fifo #(
        .WIDTH ($bits(ld_resp_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_load_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (ld_valid && ld_ready),
        .push_dat (push_ent),
        .pop      (grant_l),
        .head_dat (head_ent),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // ---------------- grant ----------------
    // A commit to a register with a load still in flight would be overwritten
    // by the later load response, so it waits until the load has written back.
    assign l_elig = !fifo_empty;
    assign p_elig = pipe_valid && !((pipe_rd != '0) && busy_q[pipe_rd]);

    always_comb begin
        grant_l = 1'b0;
        grant_p = 1'b0;
        if (l_elig && p_elig && (starve_cnt == STALL_MAX)) begin
            grant_p = 1'b1;
        end else if (l_elig) begin
            grant_l = 1'b1;
        end else if (p_elig) begin
            grant_p = 1'b1;
        end
    end

    assign pipe_ready = grant_p;

    // Counts consecutive cycles an eligible commit lost to the load side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (p_elig && !grant_p) begin
            if (starve_cnt != STALL_MAX) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    // ---------------- scoreboard ----------------
    // Set is applied after clear so a same-cycle reissue to the retiring reg stays busy.
    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (ld_issue) begin
            busy_set[ld_issue_rd] = 1'b1;
        end
        if (grant_l) begin
            busy_clr[head_ent.rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= ((busy_q & ~busy_clr) | busy_set) & {{31{1'b1}}, 1'b0};
        end
    end

    assign rd_busy = busy_q;

    // ---------------- output stage ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_sel <= WB_ALU;
            wb_mem <= '0;
            wb_alu <= '0;
            wb_pc4 <= '0;
            rf_we  <= 1'b0;
            rf_rd  <= '0;
        end else if (grant_l) begin
            wb_sel <= WB_MEM;
            wb_mem <= head_ent.data;
            rf_rd  <= head_ent.rd;
            rf_we  <= (head_ent.rd != '0);
        end else if (grant_p) begin
            wb_sel <= pipe_wb_sel;
            wb_alu <= pipe_alu;
            wb_pc4 <= pipe_pc4;
            rf_rd  <= pipe_rd;
            rf_we  <= (pipe_rd != '0) && wb_sel_legal(pipe_wb_sel);
        end else begin
            rf_we  <= 1'b0;
        end
    end

    // ---------------- protocol checks ----------------
    a_legal_sel: assert property (@(posedge clk) disable iff (rst)
        grant_p |-> wb_sel_legal(pipe_wb_sel));

    a_no_reissue: assert property (@(posedge clk) disable iff (rst)
        (ld_issue && (ld_issue_rd != '0)) |-> !busy_q[ld_issue_rd]);

endmodule
